// File: rtl/aes_mm_ctrl.sv
// aes_mm_ctrl: memory-mapped slave front end for an iterative AES round engine,
// with a double-buffered input block, a result FIFO, status, interrupt and write backpressure.
module aes_mm_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 11,
  parameter int NUM_ROUNDS = 10,
  parameter int OUT_DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  output logic [DATA_W-1:0] readdata,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic              waitrequest,
  output logic              irq,
  output logic              eng_enable,
  output logic              eng_mode,
  output logic [3:0]        eng_round,
  output logic [127:0]      eng_text_in,
  input  logic [127:0]      eng_text_out,
  input  logic [127:0]      eng_rkey
);
  localparam int WORDS = 128 / DATA_W;
  localparam int WC_W  = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int FC_W  = $clog2(OUT_DEPTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

  logic [WC_W-1:0] r_wcnt;
  logic [127:0]    r_shift, r_pend_buf;
  logic            r_pending, r_mode, r_irq_en, r_eng_mode;
  logic [1:0]      r_state;
  logic [3:0]      r_rnd;
  logic [7:0]      r_blocks;
  logic [127:0]    r_fifo [OUT_DEPTH];
  logic [FC_W-1:0] r_cnt;

  logic            w_last, w_din, w_din_acc, w_ctrl_wr, w_flush, w_rd;
  logic            w_out_valid, w_out_full, w_start, w_push, w_pop, w_busy;
  logic [127:0]    w_shift_nx;
  logic [15:0]     w_status;
  logic [DATA_W-1:0] w_dout;
  logic [FC_W-1:0] w_widx;

  assign w_last      = r_wcnt == WC_W'(WORDS - 1);
  assign w_din       = chipselect & write & (address == '0);
  assign waitrequest = w_din & w_last & r_pending;
  assign w_din_acc   = w_din & ~waitrequest;
  assign w_ctrl_wr   = chipselect & write & (address == ADDR_W'(1));
  assign w_flush     = w_ctrl_wr & writedata[2];
  assign w_shift_nx  = (r_shift << DATA_W) | 128'(writedata);
  assign w_out_valid = r_cnt != '0;
  assign w_out_full  = r_cnt == FC_W'(OUT_DEPTH);
  assign w_busy      = r_state != S_IDLE;
  assign w_start     = ~w_busy & r_pending & ~w_out_full;
  assign w_push      = r_state == S_DONE;
  assign w_rd        = chipselect & read;
  assign w_pop       = w_rd & (address == ADDR_W'(3 + WORDS - 1)) & w_out_valid;
  assign w_widx      = w_pop ? r_cnt - 1'b1 : r_cnt;
  assign w_status    = {r_blocks, 4'b0, w_out_full, w_out_valid, r_pending, w_busy};

  // mode is taken straight from CTRL in the start cycle so the engine sees it from round 0
  assign eng_enable  = w_start | (r_state == S_RUN);
  assign eng_mode    = w_start ? r_mode : r_eng_mode;
  assign eng_round   = r_state == S_RUN ? r_rnd : 4'd0;
  assign eng_text_in = w_start ? r_pend_buf ^ eng_rkey : r_state == S_RUN ? eng_text_out : '0;
  assign irq         = r_irq_en & w_out_valid;

  always_comb begin
    w_dout = '0;
    for (int i = 0; i < WORDS; i++)
      if (address == ADDR_W'(3 + i)) w_dout = r_fifo[0][127 - i*DATA_W -: DATA_W];
  end

  assign readdata = ~w_rd ? '0 :
                    address == ADDR_W'(1) ? DATA_W'({r_irq_en, r_mode}) :
                    address == ADDR_W'(2) ? DATA_W'(w_status) :
                    w_out_valid ? w_dout : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wcnt     <= '0;
      r_shift    <= '0;
      r_pend_buf <= '0;
      r_pending  <= 1'b0;
      r_mode     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_eng_mode <= 1'b0;
      r_state    <= S_IDLE;
      r_rnd      <= '0;
      r_blocks   <= '0;
      r_cnt      <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      r_wcnt    <= w_flush ? '0 : w_din_acc ? (w_last ? '0 : r_wcnt + 1'b1) : r_wcnt;
      r_pending <= ~w_flush & ((r_pending & ~w_start) | (w_din_acc & w_last));
      if (w_din_acc) r_shift <= w_shift_nx;
      if (w_din_acc && w_last) r_pend_buf <= w_shift_nx;
      if (w_ctrl_wr) begin
        r_mode   <= writedata[0];
        r_irq_en <= writedata[1];
      end
      if (w_start) begin
        r_state    <= S_RUN;
        r_rnd      <= 4'd1;
        r_eng_mode <= r_mode;
      end else if (r_state == S_RUN) begin
        if (r_rnd == 4'(NUM_ROUNDS)) r_state <= S_DONE;
        else r_rnd <= r_rnd + 4'd1;
      end else if (w_push) begin
        r_state  <= S_IDLE;
        r_blocks <= r_blocks + 8'd1;
      end
      // flush empties the FIFO but a block finishing in the same cycle survives
      if (w_flush) begin
        r_cnt <= FC_W'(w_push);
        if (w_push) r_fifo[0] <= eng_text_out;
      end else begin
        if (w_pop)
          for (int i = 0; i < OUT_DEPTH - 1; i++) r_fifo[i] <= r_fifo[i+1];
        if (w_push) r_fifo[w_widx] <= eng_text_out;
        r_cnt <= r_cnt + FC_W'(w_push) - FC_W'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_aes_mm_ctrl.sv
// tb_aes_mm_ctrl: AES engine model plus scoreboard bench for aes_mm_ctrl.
module tb_aes_mm_ctrl;
  localparam int DW = 32, AW = 11, NR = 10, OD = 2, WORDS = 4;

  logic clock = 1'b0, reset = 1'b1;
  logic chipselect, read, write, waitrequest, irq, eng_enable, eng_mode;
  logic [AW-1:0] address;
  logic [DW-1:0] readdata, writedata;
  logic [3:0] eng_round;
  logic [127:0] eng_text_in, eng_text_out, eng_rkey;
  logic [127:0] eng_st = '0;

  aes_mm_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_ROUNDS(NR), .OUT_DEPTH(OD)) dut (
    .clock(clock), .reset(reset), .chipselect(chipselect), .address(address),
    .read(read), .readdata(readdata), .write(write), .writedata(writedata),
    .waitrequest(waitrequest), .irq(irq), .eng_enable(eng_enable), .eng_mode(eng_mode),
    .eng_round(eng_round), .eng_text_in(eng_text_in), .eng_text_out(eng_text_out),
    .eng_rkey(eng_rkey));

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];
  logic [127:0] rk [16];
  logic [127:0] exp_q [$];
  int rnd_log [$];
  int mode_log [$];
  bit cur_mode = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [127:0] sub_b(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isb[s[127-8*i -: 8]] : sb[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shr(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c + (inv ? 4 - r : r)) % 4) + r;
        o[127-8*(4*c+r) -: 8] = s[127-8*src -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mixc(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [31:0] m;
    logic [7:0] v;
    m = inv ? 32'h0e0b0d09 : 32'h02030101;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        v = 0;
        for (int j = 0; j < 4; j++) v ^= gm(m[31-8*j -: 8], s[127-8*(4*c+(r+j)%4) -: 8]);
        o[127-8*(4*c+r) -: 8] = v;
      end
    return o;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k, input bit last);
    logic [127:0] t;
    t = shr(sub_b(s, 0), 0);
    if (!last) t = mixc(t, 0);
    return t ^ k;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k, input bit last);
    logic [127:0] t;
    t = sub_b(shr(s, 1), 1) ^ k;
    if (!last) t = mixc(t, 1);
    return t;
  endfunction

  // whole-block reference: full cipher or inverse cipher
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input bit mode);
    logic [127:0] s;
    s = pt ^ (mode ? rk[NR] : rk[0]);
    for (int r = 1; r <= NR; r++)
      s = mode ? dec_round(s, rk[NR-r], r == NR) : enc_round(s, rk[r], r == NR);
    return s;
  endfunction

  // engine model: one round per enabled cycle, round keys ordered by mode
  assign eng_text_out = eng_st;
  always_comb eng_rkey = eng_mode ? rk[4'(NR) - eng_round] : rk[eng_round];
  always @(posedge clock)
    if (eng_enable)
      eng_st <= eng_round == 0 ? eng_text_in :
                eng_mode ? dec_round(eng_text_in, rk[4'(NR) - eng_round], eng_round == 4'(NR))
                         : enc_round(eng_text_in, rk[eng_round], eng_round == 4'(NR));

  always @(negedge clock)
    if (eng_enable) begin
      rnd_log.push_back(int'(eng_round));
      mode_log.push_back(int'(eng_mode));
    end

  // scoreboard monitor: every DOUT read is checked against the queue head; the last word pops it
  always @(negedge clock) begin : mon
    int w;
    logic [127:0] h;
    if (chipselect && read && int'(address) >= 3 && int'(address) < 3 + WORDS) begin
      w = int'(address) - 3;
      h = exp_q.size() > 0 ? exp_q[0] : '0;
      chk("dout_word", readdata, h[127-DW*w -: DW]);
      if (w == WORDS - 1 && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    chipselect = 0; read = 0; write = 0; address = '0; writedata = '0;
  endtask

  task automatic rd(input int a, output logic [DW-1:0] d);
    chipselect = 1; read = 1; address = AW'(a);
    @(negedge clock);
    d = readdata;
    @(posedge clock); #1;
    bus_idle();
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input int budget, output bit ok);
    chipselect = 1; write = 1; address = AW'(a); writedata = d; ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (!waitrequest) begin
        ok = 1;
        @(posedge clock); #1;
        break;
      end
      @(posedge clock); #1;
    end
    bus_idle();
  endtask

  task automatic set_ctrl(input logic [DW-1:0] v);
    bit ok;
    wr(1, v, 4, ok);
    chk("ctrl_accept", ok, 1);
    cur_mode = v[0];
  endtask

  task automatic send_block(input logic [127:0] b, input int last_budget, output bit ok);
    for (int i = 0; i < WORDS - 1; i++) begin
      wr(0, b[127-DW*i -: DW], 4, ok);
      chk("din_accept", ok, 1);
    end
    wr(0, b[DW-1:0], last_budget, ok);
    if (ok) exp_q.push_back(aes_ref(b, cur_mode));
  endtask

  task automatic wait_status(input logic [15:0] mask, input string nm);
    logic [DW-1:0] d;
    bit hit = 0;
    for (int i = 0; i < 80 && !hit; i++) begin
      rd(2, d);
      hit = (d[15:0] & mask) == mask;
    end
    chk(nm, hit, 1);
  endtask

  task automatic read_block();
    logic [DW-1:0] d;
    for (int i = 0; i < WORDS; i++) rd(3 + i, d);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] inv [256];
    logic [7:0] b, rc;
    logic [15:0] bb;
    logic [31:0] w [64];
    logic [31:0] t;
    logic [127:0] key, blk [4], ta, tb2;
    logic [DW-1:0] d;
    logic [127:0] fips_ct;
    bit ok, found;
    bus_idle();
    inv[0] = 0;
    for (int x = 1; x < 256; x++)
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv[x] = 8'(y);
    for (int x = 0; x < 256; x++) begin
      bb = {inv[x], inv[x]};
      b = inv[x] ^ bb[14:7] ^ bb[13:6] ^ bb[12:5] ^ bb[11:4] ^ 8'h63;
      sb[x] = b;
      isb[b] = 8'(x);
    end
    key = 128'h000102030405060708090a0b0c0d0e0f;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 4 * (NR + 1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = r <= NR ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    tick(3);
    reset = 0;
    // reset state
    chk("rst_eng_enable", eng_enable, 0);
    chk("rst_eng_mode", eng_mode, 0);
    chk("rst_eng_round", eng_round, 0);
    chk("rst_eng_text_in", eng_text_in, 0);
    chk("rst_waitrequest", waitrequest, 0);
    chk("rst_irq", irq, 0);
    chk("rst_readdata_idle", readdata, 0);
    rd(2, d); chk("rst_status", d, 0);
    rd(1, d); chk("rst_ctrl", d, 0);
    rd(6, d);
    rd(100, d); chk("unmapped_read", d, 0);

    // 1: FIPS encrypt vector and exact latency
    fips_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    send_block(128'h00112233445566778899aabbccddeeff, 4, ok);
    chk("t1_accept", ok, 1);
    tick(11);
    rd(2, d); chk("t1_status_done_cycle", d, 32'h0001);
    rd(2, d); chk("t1_status_valid", d, 32'h0104);
    for (int i = 0; i < WORDS; i++) begin
      rd(3 + i, d); chk("t1_dout_fips", d, fips_ct[127-32*i -: 32]);
    end
    rd(2, d); chk("t1_status_popped", d, 32'h0100);

    // 2: decrypt, mode held per block, round sequence
    set_ctrl(1);
    rnd_log.delete(); mode_log.delete();
    send_block(fips_ct, 4, ok);
    chk("t2_accept", ok, 1);
    set_ctrl(0);
    rd(1, d); chk("t2_ctrl_readback", d, 0);
    wait_status(16'h0004, "t2_wait_out");
    ta = 128'h00112233445566778899aabbccddeeff;
    for (int i = 0; i < WORDS; i++) begin
      rd(3 + i, d); chk("t2_dout_fips", d, ta[127-32*i -: 32]);
    end
    chk("t2_enable_cycles", rnd_log.size(), NR + 1);
    for (int i = 0; i < rnd_log.size() && i <= NR; i++) begin
      chk("t2_round_seq", rnd_log[i], i);
      chk("t2_mode_held", mode_log[i], 1);
    end
    rd(2, d); chk("t2_status", d, 32'h0200);

    // 3: fill FIFO, third block pending, fourth stalls until a pop
    for (int k = 0; k < 4; k++) blk[k] = rnd128();
    send_block(blk[0], 4, ok); chk("t3_b0", ok, 1);
    send_block(blk[1], 4, ok); chk("t3_b1", ok, 1);
    send_block(blk[2], 60, ok); chk("t3_b2", ok, 1);
    send_block(blk[3], 20, ok); chk("t3_b3_stalled", ok, 0);
    rd(2, d); chk("t3_status_full", d, 32'h040E);
    read_block();
    wr(0, blk[3][DW-1:0], 50, ok);
    chk("t3_b3_retry", ok, 1);
    if (ok) exp_q.push_back(aes_ref(blk[3], cur_mode));
    for (int k = 0; k < 3; k++) begin
      wait_status(16'h0004, "t3_wait_out");
      read_block();
    end

    // 4: pop of the last DOUT word in the DONE cycle
    ta = rnd128(); tb2 = rnd128();
    send_block(ta, 4, ok); chk("t4_a", ok, 1);
    wait_status(16'h0004, "t4_wait_a");
    for (int i = 0; i < WORDS - 1; i++) rd(3 + i, d);
    send_block(tb2, 4, ok); chk("t4_b", ok, 1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (eng_enable && eng_round == 4'(NR)) found = 1;
      tick(1);
    end
    chk("t4_reach_done", found, 1);
    rd(6, d);
    rd(2, d); chk("t4_status_count1", d, 32'h0804);
    read_block();
    rd(2, d); chk("t4_status_empty", d, 32'h0800);

    // 5: flush discards partial words, pending block and FIFO contents
    wr(0, $urandom, 4, ok);
    wr(0, $urandom, 4, ok);
    set_ctrl(4);
    rd(2, d); chk("t5_status_after_flush", d, 32'h0800);
    rd(1, d); chk("t5_flush_reads0", d, 0);
    send_block(rnd128(), 4, ok); chk("t5_fresh", ok, 1);
    wait_status(16'h0004, "t5_wait_fresh");
    read_block();
    for (int k = 0; k < 3; k++) begin
      send_block(rnd128(), 60, ok); chk("t5_fill", ok, 1);
    end
    wait_status(16'h0008, "t5_wait_full");
    rd(2, d); chk("t5_status_full", d, 32'h0B0E);
    set_ctrl(4);
    exp_q.delete();
    rd(2, d); chk("t5_status_flushed", d, 32'h0B00);
    rd(6, d);

    // 6: reset mid-block, recovery, interrupt
    send_block(rnd128(), 4, ok); chk("t6_accept", ok, 1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (eng_enable && eng_round == 4'd5) found = 1;
      else tick(1);
    end
    chk("t6_reach_round5", found, 1);
    reset = 1;
    tick(1);
    reset = 0;
    exp_q.delete();
    cur_mode = 0;
    chk("t6_enable_off", eng_enable, 0);
    chk("t6_round_zero", eng_round, 0);
    chk("t6_text_in_zero", eng_text_in, 0);
    rd(2, d); chk("t6_status_zero", d, 0);
    set_ctrl(2);
    send_block(rnd128(), 4, ok); chk("t6_new_block", ok, 1);
    chk("t6_irq_before", irq, 0);
    wait_status(16'h0004, "t6_wait_out");
    chk("t6_irq_set", irq, 1);
    read_block();
    chk("t6_irq_clear", irq, 0);
    rd(2, d); chk("t6_status_after", d, 32'h0100);

    // random mix of modes, interrupt enable and block pairs
    for (int k = 0; k < 6; k++) begin
      int nb;
      bit en, m;
      m = 1'($urandom % 2); en = 1'($urandom % 2);
      set_ctrl({30'b0, en, m});
      nb = 1 + int'($urandom % 2);
      for (int j = 0; j < nb; j++) begin
        send_block(rnd128(), 40, ok); chk("rnd_accept", ok, 1);
      end
      for (int j = 0; j < nb; j++) begin
        wait_status(16'h0004, "rnd_wait_out");
        chk("rnd_irq", irq, en);
        read_block();
      end
      chk("rnd_irq_idle", irq, 0);
    end
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
